// File: rtl/tone_detector_if.sv
// tone_detector_if: pin input and status outputs of tone_detector; carries irq when TONE_DET_IRQ_EN is defined
interface tone_detector_if;
    logic        tone_in;
    logic        tone_a;
    logic        tone_b;
    logic        err;
    logic [15:0] period;
`ifdef TONE_DET_IRQ_EN
    logic        irq;
    modport master(output tone_in, input tone_a, tone_b, period, err, irq);
    modport slave(input tone_in, output tone_a, tone_b, period, err, irq);
`else
    modport master(output tone_in, input tone_a, tone_b, period, err);
    modport slave(input tone_in, output tone_a, tone_b, period, err);
`endif
endinterface

// File: rtl/tone_detector.sv
// tone_detector: measures half-periods of a square wave and locks on tone A or B; TONE_DET_IRQ_EN adds a lock-change irq
module tone_detector #(
    parameter int A_HALF   = 12500,
    parameter int B_HALF   = 16666,
    parameter int TOL      = 500,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 40000
) (
    input logic             clk,
    input logic             rst,
    tone_detector_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCK_A, LOCK_B} state_t;
    typedef enum logic [1:0] {C_NONE, C_A, C_B} cls_t;
    state_t      state, state_nx;
    cls_t        cls, last_cls, last_cls_nx;
    logic [2:0]  sync;
    logic [15:0] hp_cnt, period_q;
    logic [3:0]  match_cnt, match_nx;
    logic        edge_det, timeout, classify;
    logic        tone_a_q, tone_b_q, err_q, tone_a_nx, tone_b_nx, err_nx;

    assign edge_det = sync[2] ^ sync[1];
    assign classify = edge_det && state != IDLE;
    assign timeout  = !edge_det && state != IDLE && hp_cnt == 16'(TIMEOUT);
    assign cls = (int'(hp_cnt) >= A_HALF - TOL && int'(hp_cnt) <= A_HALF + TOL) ? C_A :
                 (int'(hp_cnt) >= B_HALF - TOL && int'(hp_cnt) <= B_HALF + TOL) ? C_B : C_NONE;

    assign bus.tone_a = tone_a_q;
    assign bus.tone_b = tone_b_q;
    assign bus.err    = err_q;
    assign bus.period = period_q;

    // synchronize the pin and time the current half-period, saturating rather than wrapping
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync   <= 3'b000;
            hp_cnt <= 16'd0;
        end else begin
            sync   <= {sync[1:0], bus.tone_in};
            hp_cnt <= edge_det ? 16'd0 : hp_cnt + 16'(hp_cnt != 16'hFFFF);
        end

    // run length of identical classifications and the last measured half-period
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            match_cnt <= 4'd0;
            last_cls  <= C_NONE;
            period_q  <= 16'd0;
        end else begin
            match_cnt <= match_nx;
            last_cls  <= last_cls_nx;
            if (classify) period_q <= hp_cnt;
        end

    // NONE breaks the run, a new class restarts it at one, a repeat extends it up to LOCK_CNT
    always_comb begin
        match_nx    = match_cnt;
        last_cls_nx = last_cls;
        if (timeout) match_nx = 4'd0;
        else if (classify) begin
            match_nx    = cls == C_NONE ? 4'd0 :
                          cls != last_cls ? 4'd1 :
                          match_cnt >= 4'(LOCK_CNT) ? match_cnt : match_cnt + 4'd1;
            last_cls_nx = cls == C_NONE ? last_cls : cls;
        end
    end

    // next state: the first edge out of IDLE only starts timing; locks hold until a non-matching edge
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = edge_det ? MEASURE : IDLE;
        else if (timeout) state_nx = IDLE;
        else if (classify)
            state_nx = state == MEASURE ? (match_nx == 4'(LOCK_CNT) ? (cls == C_A ? LOCK_A : LOCK_B) : MEASURE) :
                       state == LOCK_A  ? (cls == C_A ? LOCK_A : MEASURE) :
                                          (cls == C_B ? LOCK_B : MEASURE);
    end

    // output decodes taken from the next state so they appear one clock after the deciding edge
    always_comb begin
        tone_a_nx = state_nx == LOCK_A;
        tone_b_nx = state_nx == LOCK_B;
        err_nx    = classify && cls == C_NONE;
    end

    // state register and registered outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            tone_a_q <= 1'b0;
            tone_b_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            tone_a_q <= tone_a_nx;
            tone_b_q <= tone_b_nx;
            err_q    <= err_nx;
        end

`ifdef TONE_DET_IRQ_EN
    logic irq_q;
    assign bus.irq = irq_q;

    // one-clock pulse coinciding with any change of the tone outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) irq_q <= 1'b0;
        else irq_q <= {tone_b_nx, tone_a_nx} != {tone_b_q, tone_a_q};
`endif
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: random and directed half-periods against an event-level model of the tone detector
module tb_tone_detector;
    localparam int A  = 125;
    localparam int B  = 166;
    localparam int T  = 5;
    localparam int L  = 4;
    localparam int TO = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tone_detector_if tif();
    tone_detector #(.A_HALF(A), .B_HALF(B), .TOL(T), .LOCK_CNT(L), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(tif)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: pin samples of the last three clocks, time since last edge, run length and lock
    bit hist[3];
    bit active, m_err, ev;
    int since, run, lock, last_cls, m_period, meas, c, prev;
`ifdef TONE_DET_IRQ_EN
    bit m_irq;
`endif

    function automatic int cls_of(int v);
        if (v >= A - T && v <= A + T) return 1;
        if (v >= B - T && v <= B + T) return 2;
        return 0;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            hist = '{0, 0, 0};
            active = 0; m_err = 0; since = 0; run = 0; lock = 0; last_cls = 0; m_period = 0;
`ifdef TONE_DET_IRQ_EN
            m_irq = 0;
`endif
        end else begin
            prev = lock;
            m_err = 0;
            ev = hist[1] != hist[2];
            if (ev) begin
                meas = since;
                since = 0;
                if (!active) active = 1;
                else begin
                    c = cls_of(meas);
                    m_period = meas;
                    if (c == 0) begin
                        m_err = 1;
                        run = 0;
                        lock = 0;
                    end else begin
                        run = (c == last_cls) ? (run < L ? run + 1 : L) : 1;
                        last_cls = c;
                        if (lock != 0 && lock != c) lock = 0;
                        else if (lock == 0 && run == L) lock = c;
                    end
                end
            end else begin
                if (active && since == TO) begin
                    active = 0;
                    lock = 0;
                    run = 0;
                end
                since = since < 65535 ? since + 1 : 65535;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = tif.tone_in;
`ifdef TONE_DET_IRQ_EN
            m_irq = lock != prev;
`endif
        end
    end

    always @(negedge clk) begin
        chk("tone_a", 16'(tif.tone_a), 16'(lock == 1));
        chk("tone_b", 16'(tif.tone_b), 16'(lock == 2));
        chk("period", tif.period, 16'(m_period));
        chk("err", 16'(tif.err), 16'(m_err));
`ifdef TONE_DET_IRQ_EN
        chk("irq", 16'(tif.irq), 16'(m_irq));
`endif
    end

    // toggle the pin, then hold n+1 clocks so hp_cnt reads n when the next toggle is seen
    task automatic hp(int n);
        @(negedge clk);
        tif.tone_in = ~tif.tone_in;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, n;
        tif.tone_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tone_a", 16'(tif.tone_a), 16'd0);
        chk("rst_period", tif.period, 16'd0);
        chk("rst_err", 16'(tif.err), 16'd0);
        rst = 1'b1;
        repeat (500) @(negedge clk);
        chk("idle_tone_a", 16'(tif.tone_a), 16'd0);
        chk("idle_period", tif.period, 16'd0);
        repeat (4) hp(A);
        chk("pre_lock_a", 16'(tif.tone_a), 16'd0);
        hp(A);
        chk("lock_a", 16'(tif.tone_a), 16'd1);
        chk("lock_a_period", tif.period, 16'(A));
        chk("lock_a_tone_b", 16'(tif.tone_b), 16'd0);
        repeat (2) hp(B);
        chk("switch_drop_a", 16'(tif.tone_a), 16'd0);
        chk("switch_no_b", 16'(tif.tone_b), 16'd0);
        repeat (3) hp(B);
        chk("lock_b", 16'(tif.tone_b), 16'd1);
        chk("lock_b_period", tif.period, 16'(B));
        hp(80);
        hp(B);
        chk("short_period", tif.period, 16'd80);
        chk("short_drop_b", 16'(tif.tone_b), 16'd0);
        repeat (4) hp(B);
        chk("relock_b", 16'(tif.tone_b), 16'd1);
        repeat (5) hp(A);
        chk("relock_a", 16'(tif.tone_a), 16'd1);
        hp(A + 3);
        hp(TO - 20);
        chk("pre_timeout_a", 16'(tif.tone_a), 16'd1);
        chk("pre_timeout_period", tif.period, 16'(A + 3));
        repeat (40) @(negedge clk);
        chk("timeout_a", 16'(tif.tone_a), 16'd0);
        hp(A);
        chk("idle_edge_period", tif.period, 16'(A + 3));
        hp(A - T);
        hp(A + T);
        hp(A - T);
        hp(A + T);
        chk("band_edges_lock", 16'(tif.tone_a), 16'd1);
        chk("band_low_period", tif.period, 16'(A - T));
        hp(A - T - 1);
        hp(A);
        chk("below_band_drop", 16'(tif.tone_a), 16'd0);
        chk("below_band_period", tif.period, 16'(A - T - 1));
        hp(A + T + 1);
        hp(A);
        chk("above_band_period", tif.period, 16'(A + T + 1));
        repeat (4) hp(A);
        chk("pre_reset_lock", 16'(tif.tone_a), 16'd1);
        #3 rst = 1'b0;
        #1 chk("async_reset_a", 16'(tif.tone_a), 16'd0);
        chk("async_reset_period", tif.period, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            n = k < 4 ? A - T - 2 + $urandom_range(0, 2 * T + 4) :
                k < 7 ? B - T - 2 + $urandom_range(0, 2 * T + 4) :
                k == 7 ? $urandom_range(3, 250) :
                k == 8 ? (($urandom_range(0, 1) == 0) ? A - T : B + T) :
                TO + $urandom_range(0, 60);
            hp(n);
        end
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
